// File: rtl/fdma_wr_arbiter.sv
// Round-robin arbiter sharing one FDMA write channel between N_REQ video writers.
// Optional watchdog enabled by defining FDMA_WR_ARB_TIMEOUT_EN.
module fdma_wr_arbiter #(
  parameter int N_REQ          = 2,
  parameter int AXI_ADDR_WIDTH = 29,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int TIMEOUT_CYC    = 4096
) (
  input  logic                              I_axi_clk,
  input  logic                              I_rst,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]   I_req_waddr,
  input  logic [N_REQ-1:0]                  I_req_wareq,
  input  logic [N_REQ*16-1:0]               I_req_wsize,
  output logic [N_REQ-1:0]                  O_req_wbusy,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]   I_req_wdata,
  output logic [N_REQ-1:0]                  O_req_wvalid,
  output logic [AXI_ADDR_WIDTH-1:0]         O_fdma_waddr,
  output logic                              O_fdma_wareq,
  output logic [15:0]                       O_fdma_wsize,
  input  logic                              I_fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]         O_fdma_wdata,
  input  logic                              I_fdma_wvalid,
`ifdef FDMA_WR_ARB_TIMEOUT_EN
  output logic                              O_arb_timeout,
`endif
  output logic [1:0]                        O_grant_idx
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StXfer = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]                state_q, state_d;
  // The grant register doubles as the round-robin pointer: it only changes on a new grant.
  logic [1:0]                grant_q;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [15:0]               wsize_q;
  logic [1:0]                pick;
  logic                      found;
  logic                      in_burst;
  logic [3:0]                req_ext;

  logic [AXI_ADDR_WIDTH-1:0] addr_arr [4];
  logic [15:0]               size_arr [4];
  logic [AXI_DATA_WIDTH-1:0] data_arr [4];

  assign req_ext = 4'(I_req_wareq);

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    if (k < N_REQ) begin : g_used
      assign addr_arr[k] = I_req_waddr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      assign size_arr[k] = I_req_wsize[k*16 +: 16];
      assign data_arr[k] = I_req_wdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end else begin : g_unused
      assign addr_arr[k] = '0;
      assign size_arr[k] = '0;
      assign data_arr[k] = '0;
    end
  end

  // Search last+1, last+2, ... modulo N_REQ for the first pending request.
  always_comb begin
    logic [2:0] sum;
    pick  = grant_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, grant_q} + 3'(i);
      if (sum >= 3'(N_REQ)) sum = sum - 3'(N_REQ);
      if (!found && req_ext[sum[1:0]]) begin
        found = 1'b1;
        pick  = sum[1:0];
      end
    end
  end

  assign in_burst = (state_q == StReq) || (state_q == StXfer);

`ifdef FDMA_WR_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_flag_q;
  logic        tmo_hit;

  assign tmo_hit       = in_burst && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
  assign O_arb_timeout = tmo_flag_q;

  always_ff @(posedge I_axi_clk) begin
    if (I_rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (!in_burst || (state_d != state_q)) tmo_cnt_q <= '0;
      else                                   tmo_cnt_q <= tmo_cnt_q + 16'd1;
      if (tmo_hit) tmo_flag_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (found) state_d = StReq;
      StReq:   if (I_fdma_wbusy) state_d = StXfer;
      StXfer:  if (!I_fdma_wbusy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef FDMA_WR_ARB_TIMEOUT_EN
    if (tmo_hit) state_d = StDone;
`endif
  end

  always_ff @(posedge I_axi_clk) begin
    if (I_rst) begin
      state_q <= StIdle;
      grant_q <= 2'(N_REQ - 1);
      waddr_q <= '0;
      wsize_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && found) begin
        grant_q <= pick;
        waddr_q <= addr_arr[pick];
        wsize_q <= size_arr[pick];
      end
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_route
    assign O_req_wbusy[k]  = in_burst && (grant_q == 2'(k));
    assign O_req_wvalid[k] = in_burst && I_fdma_wvalid && (grant_q == 2'(k));
  end

  assign O_fdma_wareq = (state_q == StReq);
  assign O_fdma_waddr = waddr_q;
  assign O_fdma_wsize = wsize_q;
  assign O_fdma_wdata = data_arr[grant_q];
  assign O_grant_idx  = grant_q;

endmodule

// File: tb/tb_fdma_wr_arbiter.sv
// Randomized self-checking bench for fdma_wr_arbiter against a transaction-level RR model.
module tb_fdma_wr_arbiter;
  localparam int N  = 3;
  localparam int AW = 29;
  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  wareq;
  logic [AW-1:0] r_addr [N];
  logic [15:0]   r_size [N];
  logic [DW-1:0] r_data [N];
  logic [N*AW-1:0] p_addr;
  logic [N*16-1:0] p_size;
  logic [N*DW-1:0] p_data;
  logic          fb_wbusy, fb_wvalid;

  logic [N-1:0]  d_wbusy, d_wvalid;
  logic [AW-1:0] d_waddr;
  logic          d_wareq;
  logic [15:0]   d_wsize;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_gidx;

  int total = 0;
  int bad   = 0;
  int m_last;
  logic [N-1:0] pend;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign p_addr[k*AW +: AW] = r_addr[k];
    assign p_size[k*16 +: 16] = r_size[k];
    assign p_data[k*DW +: DW] = r_data[k];
  end

  fdma_wr_arbiter #(
    .N_REQ          (N),
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .TIMEOUT_CYC    (4096)
  ) dut (
    .I_axi_clk     (clk),
    .I_rst         (rst),
    .I_req_waddr   (p_addr),
    .I_req_wareq   (wareq),
    .I_req_wsize   (p_size),
    .O_req_wbusy   (d_wbusy),
    .I_req_wdata   (p_data),
    .O_req_wvalid  (d_wvalid),
    .O_fdma_waddr  (d_waddr),
    .O_fdma_wareq  (d_wareq),
    .O_fdma_wsize  (d_wsize),
    .I_fdma_wbusy  (fb_wbusy),
    .O_fdma_wdata  (d_wdata),
    .I_fdma_wvalid (fb_wvalid),
    .O_grant_idx   (d_gidx)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first requester found scanning last+1, last+2, ... modulo N.
  function automatic int rr_pick(input int last, input logic [N-1:0] p);
    for (int j = 1; j <= N; j++) begin
      if (p[(last + j) % N]) return (last + j) % N;
    end
    return -1;
  endfunction

  task automatic post(input int k, input logic [AW-1:0] addr, input logic [15:0] size);
    r_addr[k] = addr;
    r_size[k] = size;
    wareq[k]  = 1'b1;
    pend[k]   = 1'b1;
  endtask

  // One burst from grant to the bubble after DONE; abort_after >= 0 resets after that many beats.
  task automatic serve(input int exp_wait, input logic [N-1:0] repost,
                       input logic [N-1:0] withdraw, input int abort_after);
    int w;
    int waited;
    int nb;
    w = rr_pick(m_last, pend);
    waited = 0;
    while (d_wareq !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("grant_seen", 128'(waited < 20), 128'(1));
    if (waited >= 20 || w < 0) return;
    if (exp_wait >= 0) check("grant_lat", 128'(waited), 128'(exp_wait));
    check("gidx", 128'(d_gidx), 128'(w));
    check("waddr", 128'(d_waddr), 128'(r_addr[w]));
    check("wsize", 128'(d_wsize), 128'(r_size[w]));
    check("wbusy_req", 128'(d_wbusy), 128'(1 << w));
    wareq[w] = 1'b0;
    pend[w]  = 1'b0;
    nb = int'(r_size[w]);
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("wareq_hold", 128'(d_wareq), 128'(1));
    end
    fb_wbusy = 1'b1;
    tick();
    check("wareq_drop", 128'(d_wareq), 128'(0));
    for (int k = 0; k < N; k++) begin
      if (repost[k] && !pend[k]) post(k, AW'($urandom), 16'($urandom_range(0, 6)));
      else if (withdraw[k] && !pend[k]) wareq[k] = 1'b1;
    end
    for (int i = 0; i < nb; i++) begin
      if (i == abort_after) begin
        rst       = 1'b1;
        fb_wvalid = 1'b1;
        tick();
        check("rst_wareq", 128'(d_wareq), 128'(0));
        check("rst_waddr", 128'(d_waddr), 128'(0));
        check("rst_wsize", 128'(d_wsize), 128'(0));
        check("rst_wbusy", 128'(d_wbusy), 128'(0));
        check("rst_wvalid", 128'(d_wvalid), 128'(0));
        check("rst_gidx", 128'(d_gidx), 128'(N - 1));
        rst       = 1'b0;
        fb_wvalid = 1'b0;
        fb_wbusy  = 1'b0;
        m_last    = N - 1;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        #1;
        check("wvalid_gap", 128'(d_wvalid), 128'(0));
        tick();
      end
      fb_wvalid = 1'b1;
      for (int k = 0; k < N; k++) r_data[k] = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("wvalid_route", 128'(d_wvalid), 128'(1 << w));
      check("wdata", 128'(d_wdata), 128'(r_data[w]));
      tick();
      fb_wvalid = 1'b0;
    end
    for (int k = 0; k < N; k++) if (withdraw[k] && !pend[k]) wareq[k] = 1'b0;
    fb_wbusy = 1'b0;
    tick();
    fb_wvalid = 1'b1;
    #1;
    check("done_wbusy", 128'(d_wbusy), 128'(0));
    check("done_wvalid", 128'(d_wvalid), 128'(0));
    check("done_wareq", 128'(d_wareq), 128'(0));
    check("done_gidx", 128'(d_gidx), 128'(w));
    fb_wvalid = 1'b0;
    m_last = w;
    tick();
    check("bubble_wareq", 128'(d_wareq), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wareq = '0;
    fb_wbusy = 1'b0;
    fb_wvalid = 1'b0;
    pend = '0;
    m_last = N - 1;
    for (int k = 0; k < N; k++) begin
      r_addr[k] = '0;
      r_size[k] = '0;
      r_data[k] = '0;
    end
    tick();
    tick();
    check("reset_wareq", 128'(d_wareq), 128'(0));
    check("reset_waddr", 128'(d_waddr), 128'(0));
    check("reset_wsize", 128'(d_wsize), 128'(0));
    check("reset_wbusy", 128'(d_wbusy), 128'(0));
    check("reset_gidx", 128'(d_gidx), 128'(N - 1));
    rst = 1'b0;
    tick();

    // Spurious beat while idle must not reach any requester.
    fb_wvalid = 1'b1;
    #1;
    check("idle_wvalid", 128'(d_wvalid), 128'(0));
    fb_wvalid = 1'b0;
    tick();

    // Single long burst from requester 0.
    post(0, AW'(32'h1000), 16'd1280);
    serve(1, '0, '0, -1);

    // Simultaneous requests, each winner re-requesting mid-burst.
    post(0, AW'($urandom), 16'd3);
    post(1, AW'($urandom), 16'd2);
    for (int b = 0; b < 3; b++) serve(1, 3'b011, '0, -1);
    serve(1, '0, '0, -1);
    serve(1, '0, '0, -1);

    // Pending request raised mid-burst is granted straight after DONE.
    post(0, AW'($urandom), 16'd8);
    serve(1, 3'b010, '0, -1);
    serve(1, '0, '0, -1);

    // Withdrawn request never produces a burst.
    post(0, AW'($urandom), 16'd4);
    serve(1, '0, 3'b100, -1);
    repeat (5) begin
      tick();
      check("no_withdrawn_grant", 128'(d_wareq), 128'(0));
    end

    // Reset after 100 of 1280 beats, then requester 0 must win first.
    post(0, AW'(32'h2000), 16'd1280);
    serve(1, '0, '0, 100);
    tick();
    post(1, AW'($urandom), 16'd2);
    post(0, AW'($urandom), 16'd2);
    serve(1, '0, '0, -1);
    serve(1, '0, '0, -1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) post(k, AW'($urandom), 16'($urandom_range(0, 8)));
      end
      if (pend == '0) post(int'($urandom_range(0, N - 1)), AW'($urandom), 16'($urandom_range(0, 8)));
      serve(1, N'($urandom), '0, -1);
    end
    for (int d = 0; d < N; d++) begin
      if (pend != '0) serve(1, '0, '0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
